seq_sdiv: RTL and testbench
===========================

SEQ_SDIV -- requirements
Module: seq_sdiv

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning divisor/remainder width; the dividend/quotient width is 2*DW.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock (sole clock).
REQ-003 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid  input  1  operand pair valid.
REQ-005 The block SHALL have port in_ready  output  1  block can accept operands.
REQ-006 The block SHALL have port dividend  input  2*DW  signed two's-complement dividend.
REQ-007 The block SHALL have port divisor  input  DW  signed two's-complement divisor.
REQ-008 The block SHALL have port out_valid  output  1  result valid.
REQ-009 The block SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 The block SHALL have port quot  output  2*DW  signed quotient.
REQ-011 The block SHALL have port rem  output  DW  signed remainder.
REQ-012 The block SHALL have port div0  output  1  divide-by-zero flag, valid with out_valid.
REQ-013 The block SHALL have port ovf  output  1  quotient-overflow flag, valid with out_valid.

Function
REQ-014 The block SHALL implement states IDLE, BUSY, FIX, DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE.
REQ-015 The block SHALL accept operands on a rising edge with in_valid&in_ready, capturing dividend, divisor, and both signs.
REQ-016 On acceptance with divisor==0, the block SHALL go directly to DONE with quot=all-ones, rem=0, div0=1, ovf=0.
REQ-017 On acceptance with dividend==-2^(2DW-1) and divisor==-1, the block SHALL go directly to DONE with quot=-2^(2DW-1) (16'h8000 at DW=8), rem=0, ovf=1, div0=0.
REQ-018 Otherwise, the block SHALL load operand magnitudes, enter BUSY, and perform one restoring shift-subtract iteration per cycle for exactly 2*DW cycles, tracked by an iteration counter.
REQ-019 After the last iteration, the block SHALL enter FIX for one cycle: negate quot if dividend and divisor signs differ; give rem the dividend's sign (truncation toward zero, |rem|<|divisor|).
REQ-020 From FIX, the block SHALL enter DONE on the next edge; normal latency is acceptance edge + 2*DW + 2 edges (18 at DW=8); div0/ovf latency is 1 edge.
REQ-021 In DONE, quot/rem/div0/ovf SHALL remain stable while out_ready=0 (unbounded backpressure).
REQ-022 In DONE with out_ready=1, the block SHALL return to IDLE on that edge; a new operand SHALL NOT be accepted on the same edge (minimum one IDLE cycle between jobs).
REQ-023 in_valid asserted outside IDLE SHALL be ignored; operand inputs SHALL be don't-care after acceptance.
REQ-024 The quot/rem/div0/ovf values in IDLE/BUSY/FIX are unspecified; checks SHALL sample only when out_valid=1.
REQ-025 The result SHALL equal the truncating signed division for every non-exceptional operand pair (remainder identity: dividend == quot*divisor + rem).

Reset
REQ-026 While rst_n=0, the block SHALL be in IDLE with in_ready=1, out_valid=0, quot=0, rem=0, div0=0, ovf=0, and counter=0, independent of clk.
REQ-027 Asserting rst_n in BUSY, FIX, or DONE SHALL abort the job immediately; no result SHALL be presented after release.
REQ-028 After rst_n deassertion, the first rising edge SHALL be able to accept operands.

Verification
REQ-029 100 / 7 -> after 18 edges: quot=14, rem=2, div0=0, ovf=0; also -100/7 -> quot=-14, rem=-2; 100/-7 -> quot=-14, rem=2; -100/-7 -> quot=14, rem=-2.
REQ-030 5 / 0 -> DONE 1 edge after acceptance: quot=16'hFFFF, rem=0, div0=1; -32768 / -1 -> quot=16'h8000, rem=0, ovf=1.
REQ-031 Backpressure: 1000/-3 with out_ready=0 for 10 cycles -> quot=-333, rem=1, held stable; in_ready=0 throughout; IDLE one edge after out_ready=1.
REQ-032 Reset mid-operation: rst_n pulled low 5 cycles into BUSY -> outputs take reset values immediately; a following 9/2 job -> quot=4, rem=1.
REQ-033 Randomized: 10,000 random pairs including -128 divisor and -32768 dividend, checked against a reference model using REQ-025 and REQ-016/017, with random in_valid/out_ready gaps.

Source files
------------

// File: rtl/seq_sdiv_if.sv
// Handshake bundle for the sequential signed divider: operand request channel and result channel.
interface seq_sdiv_if #(
    parameter int DW = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [2*DW-1:0]   dividend;
    logic [DW-1:0]     divisor;
    logic              out_valid;
    logic              out_ready;
    logic [2*DW-1:0]   quot;
    logic [DW-1:0]     rem;
    logic              div0;
    logic              ovf;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quot, rem, div0, ovf
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quot, rem, div0, ovf
    );
endinterface

// File: rtl/seq_sdiv.sv
// Sequential signed divider: 2*DW-by-DW restoring division on magnitudes, one quotient bit per cycle,
// followed by a sign-fix cycle. Divide-by-zero and the single overflow case bypass the iteration.
module seq_sdiv #(
    parameter int DW = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    seq_sdiv_if.slave bus
);
    localparam int QW = 2 * DW;
    localparam int CW = $clog2(QW);

    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count;
    logic [QW-1:0]   quot_q;
    logic [DW-1:0]   rem_q;
    logic [DW-1:0]   dmag;
    logic            sign_n, sign_d;
    logic            div0_q, ovf_q;

    logic            is_zero, is_ovf, last;
    logic [QW-1:0]   nmag_in;
    logic [DW-1:0]   dmag_in;
    logic [DW:0]     shifted, trial;

    assign is_zero = (bus.divisor == '0);
    assign is_ovf  = (bus.dividend == {1'b1, {(QW-1){1'b0}}}) && (bus.divisor == '1);
    assign last    = (count == CW'(QW - 1));
    assign nmag_in = bus.dividend[QW-1] ? -bus.dividend : bus.dividend;
    assign dmag_in = bus.divisor[DW-1]  ? -bus.divisor  : bus.divisor;

    // Partial remainder stays below dmag <= 2^(DW-1), so the shifted value never reaches bit DW
    // and trial[DW] is a clean borrow.
    assign shifted = {rem_q, quot_q[QW-1]};
    assign trial   = shifted - {1'b0, dmag};

    assign bus.quot = quot_q;
    assign bus.rem  = rem_q;
    assign bus.div0 = div0_q;
    assign bus.ovf  = ovf_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block is defaulted first, so no path can infer a latch.
    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = (is_zero || is_ovf) ? DONE : BUSY;
            end
            BUSY: if (last) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Quotient and remainder registers double as the working registers during the iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dmag   <= '0;
            sign_n <= 1'b0;
            sign_d <= 1'b0;
            div0_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    count  <= '0;
                    sign_n <= bus.dividend[QW-1];
                    sign_d <= bus.divisor[DW-1];
                    div0_q <= is_zero;
                    ovf_q  <= is_ovf;
                    rem_q  <= '0;
                    dmag   <= dmag_in;
                    if (is_zero)     quot_q <= '1;
                    else if (is_ovf) quot_q <= bus.dividend;
                    else             quot_q <= nmag_in;
                end
                BUSY: begin
                    count  <= count + 1'b1;
                    quot_q <= {quot_q[QW-2:0], ~trial[DW]};
                    rem_q  <= trial[DW] ? shifted[DW-1:0] : trial[DW-1:0];
                end
                FIX: begin
                    if (sign_n ^ sign_d) quot_q <= -quot_q;
                    if (sign_n)          rem_q  <= -rem_q;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_sdiv.sv
// Directed bench for seq_sdiv: sign combinations, exceptions, backpressure, mid-job reset, plus a
// short randomized batch against a truncating-division model.
module tb_seq_sdiv;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    seq_sdiv_if #(.DW(8)) bus ();

    seq_sdiv #(.DW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a clock edge with the block in IDLE; hold = cycles of backpressure.
    task automatic do_job(input string tag, input logic [15:0] a, input logic [7:0] b,
                          input logic [15:0] eq, input logic [7:0] er, input logic ed0,
                          input logic eov, input int elat, input int hold);
        int edges;
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.dividend = 16'($urandom);
        bus.divisor  = 8'($urandom);
        edges = 1;
        while (!bus.out_valid && edges < 40) begin
            tick();
            edges++;
        end
        check({tag, " latency"}, edges, elat);
        check({tag, " quot"}, bus.quot, eq);
        check({tag, " rem"}, bus.rem, er);
        check({tag, " div0"}, bus.div0, ed0);
        check({tag, " ovf"}, bus.ovf, eov);
        for (int i = 0; i < hold; i++) tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, " idle"}, bus.in_ready, 1'b1);
    endtask

    function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                  output logic [15:0] q, output logic [7:0] r,
                                  output logic d0, output logic ov);
        int ai, bi;
        ai = int'($signed(a));
        bi = int'($signed(b));
        d0 = 1'b0;
        ov = 1'b0;
        if (bi == 0) begin
            q = 16'hFFFF; r = 8'h00; d0 = 1'b1;
        end else if (ai == -32768 && bi == -1) begin
            q = 16'h8000; r = 8'h00; ov = 1'b1;
        end else begin
            q = 16'(ai / bi);
            r = 8'(ai % bi);
        end
    endfunction

    initial begin
        int          edges;
        logic        seen;
        logic [15:0] ra, eq;
        logic [7:0]  rb, er;
        logic        ed0, eov;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        #2;
        check("reset in_ready", bus.in_ready, 1'b1);
        check("reset out_valid", bus.out_valid, 1'b0);
        check("reset quot", bus.quot, 16'h0000);
        check("reset rem", bus.rem, 8'h00);
        check("reset div0", bus.div0, 1'b0);
        check("reset ovf", bus.ovf, 1'b0);
        #1;
        rst_n = 1'b1;

        // First edge after reset release accepts the operands.
        do_job("100/7",    16'd100,    8'd7,    16'd14,    8'd2,    1'b0, 1'b0, 18, 0);
        do_job("-100/7",   16'hFF9C,   8'd7,    16'hFFF2,  8'hFE,   1'b0, 1'b0, 18, 1);
        do_job("100/-7",   16'd100,    8'hF9,   16'hFFF2,  8'd2,    1'b0, 1'b0, 18, 0);
        do_job("-100/-7",  16'hFF9C,   8'hF9,   16'd14,    8'hFE,   1'b0, 1'b0, 18, 2);
        do_job("5/0",      16'd5,      8'd0,    16'hFFFF,  8'h00,   1'b1, 1'b0, 1,  0);
        do_job("min/-1",   16'h8000,   8'hFF,   16'h8000,  8'h00,   1'b0, 1'b1, 1,  0);
        do_job("min/-128", 16'h8000,   8'h80,   16'h0100,  8'h00,   1'b0, 1'b0, 18, 0);
        do_job("min/1",    16'h8000,   8'd1,    16'h8000,  8'h00,   1'b0, 1'b0, 18, 0);
        do_job("max/-128", 16'h7FFF,   8'h80,   16'hFF01,  8'h7F,   1'b0, 1'b0, 18, 0);
        do_job("-32767/127", 16'h8001, 8'h7F,   16'hFEFE,  8'hFF,   1'b0, 1'b0, 18, 0);
        do_job("0/5",      16'd0,      8'd5,    16'd0,     8'h00,   1'b0, 1'b0, 18, 0);
        do_job("7/-1",     16'd7,      8'hFF,   16'hFFF9,  8'h00,   1'b0, 1'b0, 18, 0);

        // Backpressure with in_valid held high throughout; new operands must be ignored.
        bus.dividend = 16'd1000;
        bus.divisor  = 8'hFD;
        bus.in_valid = 1'b1;
        tick();
        bus.dividend = 16'd7;
        bus.divisor  = 8'd1;
        edges = 1;
        while (!bus.out_valid && edges < 40) begin
            tick();
            edges++;
        end
        check("bp latency", edges, 18);
        for (int i = 0; i < 10; i++) begin
            check("bp quot", bus.quot, 16'hFEB3);
            check("bp rem", bus.rem, 8'h01);
            check("bp in_ready", bus.in_ready, 1'b0);
            check("bp out_valid", bus.out_valid, 1'b1);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp release out_valid", bus.out_valid, 1'b0);
        check("bp release no accept", bus.in_ready, 1'b1);
        bus.in_valid = 1'b0;
        tick();

        // Reset five cycles into BUSY aborts the job without waiting for a clock edge.
        bus.dividend = 16'd100;
        bus.divisor  = 8'd7;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst in_ready", bus.in_ready, 1'b1);
        check("midrst out_valid", bus.out_valid, 1'b0);
        check("midrst quot", bus.quot, 16'h0000);
        check("midrst rem", bus.rem, 8'h00);
        check("midrst div0", bus.div0, 1'b0);
        check("midrst ovf", bus.ovf, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        check("midrst no result", seen, 1'b0);
        do_job("9/2", 16'd9, 8'd2, 16'd4, 8'd1, 1'b0, 1'b0, 18, 0);

        // Randomized batch biased toward the extreme operands.
        for (int n = 0; n < 300; n++) begin
            ra = 16'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 7) == 0) ra = 16'h8000;
            case ($urandom_range(0, 9))
                0: rb = 8'h80;
                1: rb = 8'h00;
                2: rb = 8'hFF;
                default: ;
            endcase
            model(ra, rb, eq, er, ed0, eov);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
            do_job("rand", ra, rb, eq, er, ed0, eov, (ed0 || eov) ? 1 : 18,
                   int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
